motion_frame_sequencer: RTL and testbench

- Sequences whole frames through the motion detection and bounding-box pipeline.
- Accepts live pixels (valid/ready) and the matching stored-frame pixels.
- Drives the pipeline's enable, wr_background and last_in_frame strobes from its own raster counters.
- Schedules background reloads, counts returned pixels to detect frame completion, and reports status. Sits between the video ingress/frame-buffer reader and the motion pipeline.

---
 rtl/motion_frame_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_motion_frame_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_frame_sequencer.sv
// motion_frame_sequencer
// Sequences whole frames into the motion-detection / bounding-box pipeline.
// Live pixels and stored-frame pixels are accepted together (valid/ready).
// Each accepted beat is forwarded one cycle later with enable, background-write
// and end-of-frame strobes derived from internal raster counters. Returned
// pipeline valids are counted to detect when the frame has fully drained.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, stop           begin processing / finish current frame then idle (pulses)
//   continuous            restart automatically after each frame
//   bg_reload_req         request a background reload (sticky until served)
//   bg_period             automatic reload every N frames, 0 = off
//   cfg_width/cfg_height  frame size, sampled at frame start
//   src_valid/src_ready   live pixel handshake, src_pixel/mem_pixel data
//   pipe_*                pipeline drive, pipe_pixel_valid returned valids
//   busy, frame_done, frame_count, cfg_err  status
//   wdog_err              drain watchdog expiry (only with MFS_DRAIN_WDOG_EN)
//
// Build option: MFS_DRAIN_WDOG_EN adds a drain watchdog of WDOG_CYCLES cycles.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | latch frame size, decide background frame
// STREAM | accept pixels, forward beats to pipeline
// DRAIN  | wait for remaining pipeline output valids
// DONE   | frame complete, update counters, restart or idle
module motion_frame_sequencer #(
    parameter int WIDTH_BITS     = 11,
    parameter int HEIGHT_BITS    = 10,
    parameter int FRAME_CNT_BITS = 16,
    parameter int WDOG_CYCLES    = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      continuous,
    input  logic                      stop,
    input  logic                      bg_reload_req,
    input  logic [7:0]                bg_period,
    input  logic [WIDTH_BITS-1:0]     cfg_width,
    input  logic [HEIGHT_BITS-1:0]    cfg_height,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [31:0]               src_pixel,
    input  logic [31:0]               mem_pixel,
    output logic                      pipe_enable,
    output logic [31:0]               pipe_pixel,
    output logic [31:0]               pipe_mem_pixel,
    output logic                      pipe_wr_background,
    output logic                      pipe_last_in_frame,
    input  logic                      pipe_pixel_valid,
    output logic                      busy,
    output logic                      frame_done,
    output logic [FRAME_CNT_BITS-1:0] frame_count,
    output logic                      cfg_err
`ifdef MFS_DRAIN_WDOG_EN
    ,
    output logic                      wdog_err
`endif
);

    localparam int CW = WIDTH_BITS + HEIGHT_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                 state;
    logic [WIDTH_BITS-1:0]  w_q;
    logic [WIDTH_BITS-1:0]  x;
    logic [HEIGHT_BITS-1:0] h_q;
    logic [HEIGHT_BITS-1:0] y;
    logic [CW-1:0]          out_cnt;
    logic [CW-1:0]          cnt_inc;
    logic [CW-1:0]          frame_px;
    logic [7:0]             period_cnt;
    logic                   bg_frame;
    logic                   bg_pending;
    logic                   bg_sel;
    logic                   stop_latched;
    logic                   beat;
    logic                   x_end;
    logic                   last_beat;
    logic                   drain_done;

    assign frame_px   = CW'(w_q) * CW'(h_q);
    assign cnt_inc    = out_cnt + CW'(pipe_pixel_valid);
    assign drain_done = (cnt_inc >= frame_px);
    assign beat       = src_valid & src_ready;
    assign x_end      = (x == w_q - WIDTH_BITS'(1));
    assign last_beat  = x_end && (y == h_q - HEIGHT_BITS'(1));
    assign bg_sel     = bg_pending | ((bg_period != 8'd0) && (period_cnt == 8'd0));

`ifdef MFS_DRAIN_WDOG_EN
    // Reload of WDOG_CYCLES-2 puts expiry exactly WDOG_CYCLES cycles after the last valid.
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LOAD = WDW'(WDOG_CYCLES - 2);
    logic [WDW-1:0] wdog_cnt;
    logic           wdog_expire;
    assign wdog_expire = (state == S_DRAIN) && !pipe_pixel_valid && (wdog_cnt == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            w_q                <= '0;
            h_q                <= '0;
            x                  <= '0;
            y                  <= '0;
            out_cnt            <= '0;
            period_cnt         <= '0;
            bg_frame           <= 1'b0;
            bg_pending         <= 1'b1;
            stop_latched       <= 1'b0;
            src_ready          <= 1'b0;
            pipe_enable        <= 1'b0;
            pipe_pixel         <= '0;
            pipe_mem_pixel     <= '0;
            pipe_wr_background <= 1'b0;
            pipe_last_in_frame <= 1'b0;
            busy               <= 1'b0;
            frame_done         <= 1'b0;
            frame_count        <= '0;
            cfg_err            <= 1'b0;
`ifdef MFS_DRAIN_WDOG_EN
            wdog_cnt           <= WDOG_LOAD;
            wdog_err           <= 1'b0;
`endif
        end else begin
            pipe_enable        <= 1'b0;
            pipe_wr_background <= 1'b0;
            pipe_last_in_frame <= 1'b0;
            frame_done         <= 1'b0;
            cfg_err            <= 1'b0;
`ifdef MFS_DRAIN_WDOG_EN
            wdog_err           <= 1'b0;
            if (state != S_DRAIN || pipe_pixel_valid)
                wdog_cnt <= WDOG_LOAD;
            else if (wdog_cnt != '0)
                wdog_cnt <= wdog_cnt - WDW'(1);
`endif
            if (stop && state != S_IDLE)
                stop_latched <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_width == '0 || cfg_height == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    w_q       <= cfg_width;
                    h_q       <= cfg_height;
                    bg_frame  <= bg_sel;
                    // The pending request is consumed here; a new request
                    // later in this frame re-arms it for the next frame.
                    if (bg_sel)
                        bg_pending <= 1'b0;
                    x         <= '0;
                    y         <= '0;
                    out_cnt   <= '0;
                    src_ready <= 1'b1;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    // The pipeline overlaps output with input, so valids count here too.
                    out_cnt <= cnt_inc;
                    if (beat) begin
                        pipe_enable        <= 1'b1;
                        pipe_pixel         <= src_pixel;
                        pipe_mem_pixel     <= mem_pixel;
                        pipe_wr_background <= bg_frame;
                        pipe_last_in_frame <= last_beat;
                        if (last_beat) begin
                            x         <= '0;
                            y         <= '0;
                            src_ready <= 1'b0;
                            state     <= S_DRAIN;
                        end else if (x_end) begin
                            x <= '0;
                            y <= y + HEIGHT_BITS'(1);
                        end else begin
                            x <= x + WIDTH_BITS'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    out_cnt <= cnt_inc;
                    if (drain_done) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + FRAME_CNT_BITS'(1);
                        state       <= S_DONE;
                    end
`ifdef MFS_DRAIN_WDOG_EN
                    else if (wdog_expire) begin
                        frame_done  <= 1'b1;
                        wdog_err    <= 1'b1;
                        bg_pending  <= 1'b1;
                        frame_count <= frame_count + FRAME_CNT_BITS'(1);
                        state       <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    if (bg_period == 8'd0 || period_cnt >= bg_period - 8'd1)
                        period_cnt <= 8'd0;
                    else
                        period_cnt <= period_cnt + 8'd1;
                    if (continuous && !stop_latched && !stop) begin
                        state <= S_LOAD;
                    end else begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        stop_latched <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (bg_reload_req)
                bg_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_motion_frame_sequencer.sv
module tb_motion_frame_sequencer;

    localparam int WB = 11;
    localparam int HB = 10;
    localparam int FB = 16;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, continuous, stop, bg_reload_req;
    logic [7:0]    bg_period;
    logic [WB-1:0] cfg_width;
    logic [HB-1:0] cfg_height;
    logic          src_valid, src_ready;
    logic [31:0]   src_pixel, mem_pixel;
    logic          pipe_enable;
    logic [31:0]   pipe_pixel, pipe_mem_pixel;
    logic          pipe_wr_background, pipe_last_in_frame;
    logic          pipe_pixel_valid = 1'b0;
    logic          busy, frame_done, cfg_err;
    logic [FB-1:0] frame_count;
`ifdef MFS_DRAIN_WDOG_EN
    logic          wdog_err;
`endif

    always #5 clk = ~clk;

    motion_frame_sequencer #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .FRAME_CNT_BITS(FB), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .bg_reload_req(bg_reload_req), .bg_period(bg_period),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pixel(src_pixel), .mem_pixel(mem_pixel),
        .pipe_enable(pipe_enable), .pipe_pixel(pipe_pixel), .pipe_mem_pixel(pipe_mem_pixel),
        .pipe_wr_background(pipe_wr_background), .pipe_last_in_frame(pipe_last_in_frame),
        .pipe_pixel_valid(pipe_pixel_valid), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .cfg_err(cfg_err)
`ifdef MFS_DRAIN_WDOG_EN
        , .wdog_err(wdog_err)
`endif
    );

    typedef struct packed {
        logic [31:0] pix;
        logic [31:0] mem;
        logic        bg;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // event counters maintained by the monitor
    int  cyc = 0;
    int  en_cnt = 0, b2b_cnt = 0, fd_cnt = 0, ce_cnt = 0, wd_cnt = 0;
    int  last_pv = 0, wd_cyc = 0;
    bit  prev_en = 0, busy_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (pipe_enable) begin
                en_cnt++;
                if (prev_en) b2b_cnt++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat_pixel", pipe_pixel, e.pix);
                    check("beat_mem_pixel", pipe_mem_pixel, e.mem);
                    check("beat_wr_background", pipe_wr_background, e.bg);
                    check("beat_last_in_frame", pipe_last_in_frame, e.last);
                end
            end
            prev_en = pipe_enable;
            if (frame_done) fd_cnt++;
            if (cfg_err) ce_cnt++;
            if (busy) busy_seen = 1;
            if (pipe_pixel_valid) last_pv = cyc;
`ifdef MFS_DRAIN_WDOG_EN
            if (wdog_err) begin
                wd_cnt++;
                wd_cyc = cyc;
            end
`endif
        end
    end

    // pipeline model: returns one valid two cycles after each beat, up to ret_limit
    logic [1:0] dl = '0;
    int ret_sent = 0;
    int ret_limit = 1 << 30;
    always @(posedge clk) begin
        #1;
        pipe_pixel_valid = dl[1];
        dl = {dl[0], pipe_enable && (ret_sent < ret_limit)};
        if (pipe_enable && ret_sent < ret_limit) ret_sent++;
    end

    // spec-level model of background frame selection
    bit m_pend = 1;
    int m_pcnt = 0;
    int m_frames = 0;

    task automatic model_frame(input int period, output bit bg);
        bg = m_pend || (period != 0 && m_pcnt == 0);
        if (bg) m_pend = 0;
        if (period == 0 || m_pcnt >= period - 1) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream_frame(input int w, input int h, input bit toggle,
                                input bit exp_bg, input int inject_at);
        int acc = 0, x = 0, y = 0, guard = 0;
        bit ph = 1, inj = 0;
        logic [31:0] r;
        while (acc < w * h && guard < 2000) begin
            stop          = inj;
            bg_reload_req = inj;
            start         = inj;
            inj           = 0;
            src_valid     = toggle ? ph : 1'b1;
            ph            = !ph;
            r             = $urandom();
            src_pixel     = {r[31:8], 8'h00};
            mem_pixel     = $urandom();
            if (src_valid && src_ready) begin
                sb.push_back('{pix: src_pixel, mem: mem_pixel, bg: exp_bg,
                               last: (x == w - 1 && y == h - 1)});
                acc++;
                if (x == w - 1) begin
                    x = 0;
                    y++;
                end else begin
                    x++;
                end
                if (acc == inject_at) inj = 1;
            end
            tick();
            guard++;
        end
        src_valid = 0; stop = 0; bg_reload_req = 0; start = 0;
        if (guard >= 2000) check("stream_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_frames(input int target);
        int g = 0;
        while (fd_cnt < target && g < 500) begin
            tick();
            g++;
        end
        if (fd_cnt < target) check("frame_done_timeout", fd_cnt, target);
        repeat (4) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit bg;
        int fd0, en0, b2b0, ce0, wd0;
        rst = 1; start = 0; continuous = 0; stop = 0; bg_reload_req = 0; bg_period = 0;
        cfg_width = 4; cfg_height = 2; src_valid = 0; src_pixel = 0; mem_pixel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_pipe_enable", pipe_enable, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_pipe_last", pipe_last_in_frame, 0);
        check("rst_pipe_wr_bg", pipe_wr_background, 0);
        @(posedge clk);
        #1 rst = 0;
        tick();

        // single 4x2 background frame, cfg changes mid-frame ignored
        fd0 = fd_cnt; en0 = en_cnt;
        model_frame(0, bg);
        pulse_start();
        check("t1_latency_load", src_ready, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_latency_ready", src_ready, 1);
        cfg_width = 7; cfg_height = 7;
        stream_frame(4, 2, 0, bg, -1);
        m_frames++;
        wait_frames(fd0 + 1);
        check("t1_frame_done_pulses", fd_cnt - fd0, 1);
        check("t1_beats", en_cnt - en0, 8);
        check("t1_frame_count", frame_count, m_frames);
        check("t1_busy_after", busy, 0);
        check("t1_src_ready_after", src_ready, 0);
        cfg_width = 4; cfg_height = 2;

        // continuous, background every 3 frames
        fd0 = fd_cnt; en0 = en_cnt;
        bg_period = 3; continuous = 1;
        pulse_start();
        for (int f = 0; f < 4; f++) begin
            model_frame(3, bg);
            stream_frame(4, 2, 0, bg, -1);
            m_frames++;
            if (f == 3) continuous = 0;
        end
        wait_frames(fd0 + 4);
        check("t2_frame_done_pulses", fd_cnt - fd0, 4);
        check("t2_beats", en_cnt - en0, 32);
        check("t2_frame_count", frame_count, m_frames);
        check("t2_busy_after", busy, 0);

        // 3x3 with src_valid toggling
        bg_period = 0; cfg_width = 3; cfg_height = 3;
        fd0 = fd_cnt; en0 = en_cnt; b2b0 = b2b_cnt;
        model_frame(0, bg);
        pulse_start();
        stream_frame(3, 3, 1, bg, -1);
        m_frames++;
        wait_frames(fd0 + 1);
        check("t3_beats", en_cnt - en0, 9);
        check("t3_back_to_back", b2b_cnt - b2b0, 0);
        check("t3_frame_count", frame_count, m_frames);

        // zero-size configurations rejected
        ce0 = ce_cnt; busy_seen = 0;
        cfg_width = 0; cfg_height = 3;
        pulse_start();
        repeat (4) tick();
        check("t4_cfg_err_w0", ce_cnt - ce0, 1);
        check("t4_busy", busy, 0);
        check("t4_src_ready", src_ready, 0);
        cfg_width = 3; cfg_height = 0;
        pulse_start();
        repeat (4) tick();
        check("t4_cfg_err_h0", ce_cnt - ce0, 2);
        check("t4_busy_seen", busy_seen, 0);
        check("t4_frame_count", frame_count, m_frames);

        // stop and reload request mid-frame in continuous mode
        cfg_width = 4; cfg_height = 2; continuous = 1;
        fd0 = fd_cnt;
        model_frame(0, bg);
        pulse_start();
        stream_frame(4, 2, 0, bg, 3);
        m_pend = 1;
        m_frames++;
        wait_frames(fd0 + 1);
        repeat (6) tick();
        check("t5_stopped_frames", fd_cnt - fd0, 1);
        check("t5_busy_after_stop", busy, 0);
        check("t5_src_ready_after_stop", src_ready, 0);
        continuous = 0;
        fd0 = fd_cnt;
        model_frame(0, bg);
        pulse_start();
        stream_frame(4, 2, 0, bg, -1);
        m_frames++;
        wait_frames(fd0 + 1);
        check("t5_frame_count", frame_count, m_frames);

        // 1x1 frame
        cfg_width = 1; cfg_height = 1;
        fd0 = fd_cnt; en0 = en_cnt;
        model_frame(0, bg);
        pulse_start();
        stream_frame(1, 1, 0, bg, -1);
        m_frames++;
        wait_frames(fd0 + 1);
        check("t6_beats", en_cnt - en0, 1);
        check("t6_frame_count", frame_count, m_frames);

`ifdef MFS_DRAIN_WDOG_EN
        // drain watchdog: only 5 of 8 valids return
        cfg_width = 4; cfg_height = 2;
        fd0 = fd_cnt; wd0 = wd_cnt;
        ret_sent = 0; ret_limit = 5;
        model_frame(0, bg);
        pulse_start();
        stream_frame(4, 2, 0, bg, -1);
        m_frames++;
        wait_frames(fd0 + 1);
        check("t7_wdog_pulses", wd_cnt - wd0, 1);
        check("t7_wdog_delay", wd_cyc - last_pv, WD);
        check("t7_frame_done", fd_cnt - fd0, 1);
        check("t7_frame_count", frame_count, m_frames);
        check("t7_busy_after", busy, 0);
        ret_limit = 1 << 30;
        m_pend = 1;
        fd0 = fd_cnt;
        model_frame(0, bg);
        pulse_start();
        stream_frame(4, 2, 0, bg, -1);
        m_frames++;
        wait_frames(fd0 + 1);
        check("t7_reload_frame_count", frame_count, m_frames);
`endif

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
